// File: rtl/placar_pkg.sv
// Shared definitions for the scoreboard accumulator: per-channel FSM encoding
// and the latched operation record.
package placar_pkg;
    typedef enum logic [1:0] {
        S_INIT    = 2'b00,
        S_IDLE    = 2'b01,
        S_APPLY   = 2'b10,
        S_RELEASE = 2'b11
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic       mode;
        logic [1:0] val;
    } op_t;
endpackage

// File: rtl/placar_canal.sv
// One score channel: press-once FSM, operation latch and saturating add/sub
// clipped to [0, MAX_SCORE].
module placar_canal
    import placar_pkg::*;
#(
    parameter int W         = 8,
    parameter int MAX_SCORE = 199
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_n,
    input  logic [1:0]   value,
    input  logic         sub,
    input  logic         clr,
    output logic [W-1:0] tot,
    output logic         sat,
    output logic         busy
);
    localparam logic [W:0] MAX_EXT = (W+1)'(MAX_SCORE);

    state_t       state_q, state_d;
    logic [W-1:0] tot_q, tot_d;
    logic         sat_q, sat_d;
    op_t          op_q, op_d;
    logic [W:0]   res;

    // Returns {clipped, new_score}; arithmetic is one bit wider than the score.
    function automatic logic [W:0] sat_apply(input logic [W-1:0] cur, input op_t op);
        logic [W:0] ext_cur;
        logic [W:0] ext_v;
        logic [W:0] sum;
        ext_cur = {1'b0, cur};
        ext_v   = {{(W-1){1'b0}}, op.val};
        sum     = ext_cur + ext_v;
        if (op.mode == OP_ADD) begin
            if (sum > MAX_EXT) return {1'b1, MAX_EXT[W-1:0]};
            return {1'b0, sum[W-1:0]};
        end
        if (ext_v > ext_cur) return {1'b1, {W{1'b0}}};
        return {1'b0, cur - W'(op.val)};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            tot_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tot_q   <= tot_d;
            sat_q   <= sat_d;
        end
    end

    // The op latch only matters after an S_IDLE press, so it needs no reset.
    always_ff @(posedge clk) begin
        op_q <= op_d;
    end

    always_comb begin
        state_d = state_q;
        tot_d   = tot_q;
        sat_d   = 1'b0;
        op_d    = op_q;
        res     = sat_apply(tot_q, op_q);
        if (clr) begin
            state_d = S_INIT;
            tot_d   = '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    tot_d   = '0;
                    state_d = S_IDLE;
                end
                S_IDLE: begin
                    if (!btn_n) begin
                        state_d = S_APPLY;
                        op_d    = {sub, value};
                    end
                end
                S_APPLY: begin
                    tot_d   = res[W-1:0];
                    sat_d   = res[W];
                    state_d = S_RELEASE;
                end
                S_RELEASE: begin
                    if (btn_n) state_d = S_IDLE;
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    always_comb begin
        tot  = tot_q;
        sat  = sat_q;
        busy = (state_q == S_APPLY) || (state_q == S_RELEASE);
    end
endmodule

// File: rtl/placar_acumulador_multicanal.sv
// N-channel scoreboard accumulator: independent placar_canal instances with
// per-channel slices of the packed input/output vectors.
module placar_acumulador_multicanal
    import placar_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int W         = 8,
    parameter int MAX_SCORE = 199
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   btn_n,
    input  logic [2*N_CH-1:0] value,
    input  logic [N_CH-1:0]   sub,
    input  logic              clr,
    output logic [W*N_CH-1:0] tot,
    output logic [N_CH-1:0]   sat,
    output logic [N_CH-1:0]   busy
);
    if (MAX_SCORE > (2**W) - 1) begin : g_bad_max
        $error("MAX_SCORE does not fit in W bits");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        placar_canal #(
            .W        (W),
            .MAX_SCORE(MAX_SCORE)
        ) u_canal (
            .clk  (clk),
            .rst  (rst),
            .btn_n(btn_n[i]),
            .value(value[2*i +: 2]),
            .sub  (sub[i]),
            .clr  (clr),
            .tot  (tot[W*i +: W]),
            .sat  (sat[i]),
            .busy (busy[i])
        );
    end
endmodule
